// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared definitions for the banked Wishbone-to-SRAM bridge:
//   - FSM state encodings (IDLE, RD_WAIT, ACK)
//   - bank index width helpers (bank_bits / bank_idx_width)
//   - SRAM read latency range helpers (1..3 edges)
// -----------------------------------------------------------------------------
package mem_wb_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    // Supported SRAM read latency window
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Number of address bits that select a bank (0 for a single bank).
    function automatic int bank_bits(input int num_banks);
        return (num_banks <= 1) ? 0 : $clog2(num_banks);
    endfunction

    // Width of the bank index signal; never zero so it can always be declared.
    function automatic int bank_idx_width(input int num_banks);
        return (bank_bits(num_banks) < 1) ? 1 : bank_bits(num_banks);
    endfunction

    function automatic bit rd_lat_in_range(input int rd_lat);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

    // Out-of-range latencies are pulled to the nearest supported value so the
    // counter width stays fixed at two bits.
    function automatic int rd_lat_clamp(input int rd_lat);
        if (rd_lat_in_range(rd_lat)) begin
            return rd_lat;
        end
        return (rd_lat < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT_MAX;
    endfunction

endpackage

// File: rtl/mem_wb_banked_if.sv
// -----------------------------------------------------------------------------
// mem_wb_banked_if
// Wishbone classic-cycle bus bundle for the banked SRAM bridge.
//   wb_adr_i  32     byte address
//   wb_dat_i  DW     write data
//   wb_sel_i  DW/8   byte lane selects
//   wb_we_i   1      write strobe
//   wb_cyc_i  1      cycle valid
//   wb_stb_i  1      strobe
//   wb_ack_o  1      registered acknowledge
//   wb_err_o  1      registered error
//   wb_dat_o  DW     registered read data
// Signal names keep the slave-side _i/_o suffixes of the bus they replace.
// -----------------------------------------------------------------------------
interface mem_wb_banked_if #(
    parameter int DW = 32
);
    logic [31:0]     wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [DW-1:0]   wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_ack_o, wb_err_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_ack_o, wb_err_o, wb_dat_o
    );
endinterface

// File: rtl/mem_wb_bank_dec.sv
// -----------------------------------------------------------------------------
// mem_wb_bank_dec
// Bank decode for the banked Wishbone-to-SRAM bridge.
//   adr          in   32         byte address; bank index at [AW+2 +: BW]
//   req          in   1          an access is being accepted this cycle
//   bank_idx     out  IW         raw bank index (valid or not)
//   bank_en      out  NUM_BANKS  one-hot bank enable, gated by req
//   bank_invalid out  1          index does not name an existing bank
// -----------------------------------------------------------------------------
module mem_wb_bank_dec
    import mem_wb_pkg::*;
#(
    parameter int AW        = 11,
    parameter int NUM_BANKS = 3,
    localparam int BW       = bank_bits(NUM_BANKS),
    localparam int IW       = bank_idx_width(NUM_BANKS)
) (
    input  logic [31:0]          adr,
    input  logic                 req,
    output logic [IW-1:0]        bank_idx,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic                 bank_invalid
);
    // One extra bit so NUM_BANKS == 2**IW still fits in the comparison.
    localparam logic [IW:0] NB_L = (IW + 1)'(NUM_BANKS);

    // Only the bank field is decoded here; the rest of the address is
    // consumed elsewhere.
    logic unused_adr;
    assign unused_adr = ^adr;

    genvar gi;

    generate
        if (BW == 0) begin : g_single_bank
            assign bank_idx = '0;
        end else begin : g_multi_bank
            assign bank_idx = adr[AW+2 +: BW];
        end
    endgenerate

    // Non-power-of-two bank counts leave holes in the index space.
    assign bank_invalid = ({1'b0, bank_idx} >= NB_L);

    // An invalid index matches no bank, so no enable fires for it.
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_en
            assign bank_en[gi] = req & (bank_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mem_wb_banked.sv
// -----------------------------------------------------------------------------
// mem_wb_banked
// Wishbone classic-cycle slave in front of NUM_BANKS single-port SRAM macros.
// Writes ack one cycle after acceptance; reads ack one cycle after the SRAM
// data is valid (RD_LAT edges after the enable), with registered read data.
// A read in progress is abandoned if cyc/stb drop before it completes.
//
// Parameters: DW (data width), AW (word address bits per bank),
//             NUM_BANKS (1..8), RD_LAT (SRAM read latency, 1..3)
// Ports:
//   wb_clk_i    in   1            bus and SRAM clock
//   wb_rst_n_i  in   1            async assert, active-low reset
//   wb          slave modport     Wishbone bus bundle (mem_wb_banked_if)
//   mem_en_o    out  NUM_BANKS    one-hot bank enable (combinational)
//   mem_we_o    out  DW/8         byte write enables, shared by all banks
//   mem_di_o    out  DW           write data to banks
//   mem_a_o     out  AW           word address to banks
//   mem_do_i    in   NUM_BANKS*DW bank read data, bank b at [b*DW +: DW]
//
// Build option MEM_WB_ERR_EN: when defined, an access to a non-existent bank
// raises wb_err_o for one cycle instead of being acked. When undefined,
// wb_err_o stays 0, such writes are acked and dropped, such reads return 0.
// -----------------------------------------------------------------------------
module mem_wb_banked
    import mem_wb_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 11,
    parameter int NUM_BANKS = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    mem_wb_banked_if.slave          wb,
    output logic [NUM_BANKS-1:0]    mem_en_o,
    output logic [DW/8-1:0]         mem_we_o,
    output logic [DW-1:0]           mem_di_o,
    output logic [AW-1:0]           mem_a_o,
    input  logic [NUM_BANKS*DW-1:0] mem_do_i
);
    localparam int         IW       = bank_idx_width(NUM_BANKS);
    localparam int         RD_LAT_C = rd_lat_clamp(RD_LAT);
    // Counter counts the remaining wait edges after the accepting edge.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT_C - 1);

    logic [1:0]    state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [IW-1:0] bank_reg, bank_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic [DW-1:0] dat_reg, dat_next;

    logic          valid;
    logic          accept;
    logic [IW-1:0] bank_idx;
    logic          bank_invalid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] bank_rdata [NUM_BANKS];

    genvar gi;

    assign valid  = wb.wb_cyc_i & wb.wb_stb_i;
    // The SRAM strobes must be quiet while reset is held, even though the
    // FSM already sits in IDLE.
    assign accept = (state_reg == ST_IDLE) & valid & wb_rst_n_i;

    mem_wb_bank_dec #(
        .AW        (AW),
        .NUM_BANKS (NUM_BANKS)
    ) u_bank_dec (
        .adr          (wb.wb_adr_i),
        .req          (accept),
        .bank_idx     (bank_idx),
        .bank_en      (mem_en_o),
        .bank_invalid (bank_invalid)
    );

    assign mem_we_o = (accept & wb.wb_we_i) ? wb.wb_sel_i : '0;
    assign mem_di_o = wb.wb_dat_i;
    assign mem_a_o  = wb.wb_adr_i[AW+1:2];

    // Read mux on the bank latched at acceptance; an index with no bank
    // behind it falls through to zero.
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_rd_slice
            assign bank_rdata[gi] = mem_do_i[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_reg == IW'(b)) begin
                rd_data = bank_rdata[b];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bank_next  = bank_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = dat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (valid) begin
`ifdef MEM_WB_ERR_EN
                    if (bank_invalid) begin
                        err_next   = 1'b1;
                        state_next = ST_ACK;
                    end else
`endif
                    if (wb.wb_we_i) begin
                        // The SRAM takes the write on this same edge.
                        ack_next   = 1'b1;
                        state_next = ST_ACK;
                    end else begin
                        bank_next  = bank_idx;
                        cnt_next   = CNT_LOAD;
                        state_next = ST_RD_WAIT;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (!valid) begin
                    // Master gave up: drop the read without touching wb_dat_o.
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (cnt_reg == 2'd0) begin
                    dat_next   = rd_data;
                    ack_next   = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end

            ST_ACK: begin
                // Ack/err is visible this cycle; no new request is taken
                // until the cycle after.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bank_reg  <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bank_reg  <= bank_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            dat_reg   <= dat_next;
        end
    end

    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_err_o = err_reg;
    assign wb.wb_dat_o = dat_reg;

endmodule
